// File: rtl/cabac_pkg.sv
// Shared widths, FSM state type and chunk sizing for the CABAC bypass-bin decoder.
package cabac_pkg;

    localparam int RANGE_W = 9;
    localparam int VALUE_W = 32;
    localparam int BN_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bins decoded in the current chunk: min(rem, bpc); bpc is at most 8.
    function automatic logic [3:0] chunk_size(input int unsigned rem, input int unsigned bpc);
        return (rem < bpc) ? 4'(rem) : 4'(bpc);
    endfunction

endpackage

// File: rtl/ep_chunk_dec.sv
// Combinational decode of one chunk of up to BINS_PER_CYCLE bypass bins.
// Unrolled compare/subtract; stages at or beyond c_i pass v through untouched.
module ep_chunk_dec
    import cabac_pkg::*;
#(
    parameter int unsigned BINS_PER_CYCLE = 8
) (
    input  logic [VALUE_W-1:0]        v_i,
    input  logic [RANGE_W-1:0]        range_i,
    input  logic [3:0]                c_i,
    output logic [VALUE_W-1:0]        v_o,
    output logic [BINS_PER_CYCLE-1:0] bins_o
);

    logic [VALUE_W-1:0] sr;
    logic               bit_set;

    always_comb begin
        sr      = VALUE_W'(range_i) << (c_i + 4'd7);
        v_o     = v_i;
        bins_o  = '0;
        bit_set = 1'b0;
        for (int i = 0; i < int'(BINS_PER_CYCLE); i++) begin
            if (4'(i) < c_i) begin
                sr      = sr >> 1;
                bit_set = (v_o >= sr);
                bins_o  = (bins_o << 1) | BINS_PER_CYCLE'(bit_set);
                if (bit_set) begin
                    v_o = v_o - sr;
                end
            end
        end
    end

endmodule

// File: rtl/decode_bins_ep_seq.sv
// Sequential bypass-bin decoder: FSM, byte fetch handshake and result registers.
// One chunk per RUN cycle; a needed byte that is not valid stalls the chunk.
module decode_bins_ep_seq
    import cabac_pkg::*;
#(
    parameter int unsigned BINS_PER_CYCLE = 8,
    parameter int unsigned MAX_BINS       = 32,
    parameter int          CNT_W          = $clog2(MAX_BINS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     ready,
    input  logic [CNT_W-1:0]         num_bins,
    input  logic [RANGE_W-1:0]       range_in,
    input  logic [VALUE_W-1:0]       value_in,
    input  logic signed [BN_W-1:0]   bits_needed_in,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     done,
    output logic [MAX_BINS-1:0]      bins_out,
    output logic [VALUE_W-1:0]       value_out,
    output logic signed [BN_W-1:0]   bits_needed_out,
    output logic                     err
);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          rem_q, rem_d;
    logic [VALUE_W-1:0]        v_q, v_d;
    logic [BN_W-1:0]           bn_q, bn_d;
    logic [MAX_BINS-1:0]       bins_q, bins_d;
    logic [RANGE_W-1:0]        rng_q, rng_d;
    logic                      err_q, err_d;
    logic [MAX_BINS-1:0]       bins_out_q, bins_out_d;
    logic [VALUE_W-1:0]        value_out_q, value_out_d;
    logic [BN_W-1:0]           bn_out_q, bn_out_d;

    logic [3:0]                c;
    logic [BN_W:0]             bn_sum;
    logic                      need;
    logic                      stall;
    logic                      too_many;
    logic [VALUE_W-1:0]        v_sh, v_add, v_dec;
    logic [BN_W-1:0]           bn_new;
    logic [BINS_PER_CYCLE-1:0] cbins;
    logic [MAX_BINS-1:0]       bins_new;
    logic [CNT_W-1:0]          rem_new;

    assign c        = chunk_size(32'(rem_q), BINS_PER_CYCLE);
    assign bn_sum   = {bn_q[BN_W-1], bn_q} + {1'b0, c};
    // A non-negative bit count after the shift means the next byte must be merged now.
    assign need     = ~bn_sum[BN_W];
    assign stall    = need & ~byte_valid;
    assign v_sh     = v_q << c;
    assign v_add    = need ? v_sh + (VALUE_W'(byte_data) << bn_sum[2:0]) : v_sh;
    assign bn_new   = need ? BN_W'(bn_sum - 5'd8) : bn_sum[BN_W-1:0];
    assign bins_new = (bins_q << c) | MAX_BINS'(cbins);
    assign rem_new  = rem_q - CNT_W'(c);
    assign too_many = 32'(num_bins) > MAX_BINS;

    ep_chunk_dec #(
        .BINS_PER_CYCLE(BINS_PER_CYCLE)
    ) u_chunk (
        .v_i    (v_add),
        .range_i(rng_q),
        .c_i    (c),
        .v_o    (v_dec),
        .bins_o (cbins)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        v_d         = v_q;
        bn_d        = bn_q;
        bins_d      = bins_q;
        rng_d       = rng_q;
        err_d       = err_q;
        bins_out_d  = bins_out_q;
        value_out_d = value_out_q;
        bn_out_d    = bn_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rng_d  = range_in;
                    v_d    = value_in;
                    bn_d   = bits_needed_in;
                    rem_d  = num_bins;
                    bins_d = '0;
                    err_d  = too_many;
                    if (num_bins == '0 || too_many) begin
                        state_d     = DONE;
                        bins_out_d  = '0;
                        value_out_d = value_in;
                        bn_out_d    = bits_needed_in;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    v_d    = v_dec;
                    bn_d   = bn_new;
                    bins_d = bins_new;
                    rem_d  = rem_new;
                    if (rem_new == '0) begin
                        state_d     = DONE;
                        bins_out_d  = bins_new;
                        value_out_d = v_dec;
                        bn_out_d    = bn_new;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            v_q         <= '0;
            bn_q        <= '0;
            bins_q      <= '0;
            rng_q       <= '0;
            err_q       <= 1'b0;
            bins_out_q  <= '0;
            value_out_q <= '0;
            bn_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            v_q         <= v_d;
            bn_q        <= bn_d;
            bins_q      <= bins_d;
            rng_q       <= rng_d;
            err_q       <= err_d;
            bins_out_q  <= bins_out_d;
            value_out_q <= value_out_d;
            bn_out_q    <= bn_out_d;
        end
    end

    assign ready           = (state_q == IDLE);
    assign done            = (state_q == DONE);
    assign byte_ready      = (state_q == RUN) && need;
    assign err             = done && err_q;
    assign bins_out        = bins_out_q;
    assign value_out       = value_out_q;
    assign bits_needed_out = bn_out_q;

endmodule

// File: doc/decode_bins_ep_seq.md
Name: decode_bins_ep_seq

Overview:
Sequential, parametrised bypass-bin (EP) decoder for the VVC CABAC arithmetic decoder.
- Decodes num_bins equiprobable bins, up to MAX_BINS, in chunks of BINS_PER_CYCLE per cycle.
- Fetches bitstream bytes through a valid/ready handshake instead of a static byte input.
- Handles range==256 (aligned case) with results bit-identical to the generic path.
- Sits between the bitstream byte reader and the syntax-element parsers.

Parameters:
- BINS_PER_CYCLE, 8, bins decoded per RUN cycle; legal 1..8, so at most one byte is needed per chunk.
- MAX_BINS, 32, maximum num_bins per command; sets the bins_out width.
- CNT_W, $clog2(MAX_BINS+1), width of num_bins.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  command strobe; accepted only when ready=1.
- ready  out  1  high in IDLE.
- num_bins  in  CNT_W  bins to decode; sampled on start.
- range_in  in  9  current range (256..510); sampled on start.
- value_in  in  32  current m_value; sampled on start.
- bits_needed_in  in  4 signed  current m_bitsNeeded (-8..-1); sampled on start.
- byte_data  in  8  bitstream byte.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  decoder consumes byte_data this cycle if byte_valid=1.
- done  out  1  one-cycle pulse; the three result outputs are valid while it is high.
- bins_out  out  MAX_BINS  decoded bins, MSB-first, right-aligned.
- value_out  out  32  updated m_value.
- bits_needed_out  out  4 signed  updated m_bitsNeeded.
- err  out  1  pulses with done when num_bins > MAX_BINS; that command decodes 0 bins.

Behaviour:
- Reset (async, rst=1) values: state=IDLE, ready=1, byte_ready=0, done=0, err=0, bins_out=0, value_out=0, bits_needed_out=0; all internal registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Stays in IDLE while start=0.
  - start=1 latches the inputs and sets rem=num_bins and bins=0.
  - If num_bins==0 or num_bins>MAX_BINS, goes to DONE; otherwise goes to RUN.
- RUN, computed each cycle:
  - c = min(rem, BINS_PER_CYCLE).
  - bn' = bn + c; v' = v << c.
  - need = (bn' >= 0).
  - byte_ready = need.
  - If need=1 and byte_valid=0: stall. No register changes, byte_ready stays high.
  - Otherwise:
    - If need: v' += byte_data << bn'; bn' -= 8.
    - sr = range << (c+7).
    - Repeat c times: sr >>= 1; bins = (bins<<1) | (v' >= sr); if the compare is true, v' -= sr.
    - Commit v, bn, bins; rem -= c.
    - When rem reaches 0, go to DONE.
- DONE (one cycle):
  - done=1; err as defined above.
  - Result registers are updated on entry to DONE and hold their values afterwards.
  - Returns to IDLE.
- Arithmetic:
  - All value arithmetic is unsigned 32-bit; bn is signed 4-bit.
  - The invariant v < range<<7 holds between chunks.
- Aligned case (range==256): uses the same datapath; every compare reduces to a bit test. The 256 special case is never stubbed.
- Latency:
  - With byte_valid always 1: done asserts ceil(num_bins/BINS_PER_CYCLE)+1 cycles after the start cycle.
  - Each stall cycle adds one cycle.
- start while not ready: ignored.
- byte_ready is 0 outside RUN.
- Reset mid-operation: returns immediately to the reset values; any partial byte consumption is discarded (upstream is also reset).

Decomposition:
- Package cabac_pkg holds:
  - RANGE_W=9, VALUE_W=32, BN_W=4;
  - the state enum {IDLE, RUN, DONE};
  - the function for the chunk size min(rem, BINS_PER_CYCLE).
- Sub-module ep_chunk_dec: combinational decode of one chunk.
  - Inputs: v, range, c.
  - Outputs: new v and c bins.
  - Built as an unrolled BINS_PER_CYCLE-stage compare/subtract, with stages beyond c bypassed.
- The top level holds the FSM, the byte handshake and the registers.

Test Plan:
- Aligned, one byte: range=256, value=0x5500, bn=-8, n=8, byte 0xAB -> bins=0xAA, value_out=0x00AB, bn_out=-8, one byte handshake, done at cycle 2.
- Aligned, no byte needed: range=256, value=0x4000, bn=-5, n=3 -> bins=0b100, value_out=0, bn_out=-2, byte_ready never high.
- Non-aligned: range=300, value=0x8000, bn=-1, n=1, byte 0x00 -> bins=1, value_out=0x6A00, bn_out=-8.
- Multi-chunk: range=256, bn=-8, n=20 -> chunks 8, 8, 4; exactly 2 byte handshakes; done at cycle 4.
- Stall: repeat the non-aligned case with byte_valid low for 3 cycles -> done 3 cycles later, identical outputs.
- Edge cases:
  - n=0 -> done next cycle, bins=0, value and bn unchanged, no byte_ready.
  - n=33 -> err=1 with done.
  - rst asserted mid-RUN -> ready=1, byte_ready=0 immediately.
  - start while busy -> ignored.
